// File: rtl/handshake_sync_rx.sv
// Receiver for a 4-phase req/ack bundled-data link: synchronizes req, captures data,
// offers it on valid/ready, then returns ack. Optional HS_TIMEOUT_EN adds a req-stuck timeout.

module handshake_sync_rx_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             ena,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            meta <= '0;
            q    <= '0;
        end else if (ena) begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

module handshake_sync_rx #(
    parameter int WIDTH          = 8,
    parameter int CNT_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic                 ena,
    input  logic                 req_async,
    input  logic [WIDTH-1:0]     data_async,
    output logic                 ack,
    output logic [WIDTH-1:0]     data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic [CNT_WIDTH-1:0] xfer_count,
    output logic                 err_timeout
);
`ifdef HS_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, OFFER, WAIT_REQ_LOW, DRAIN} state_t;
    localparam logic [15:0] TIMEOUT_LIM = TIMEOUT_CYCLES[15:0];
    logic [15:0] timer;
`else
    typedef enum logic [1:0] {IDLE, OFFER, WAIT_REQ_LOW} state_t;
`endif

    state_t state;
    logic   req_s;

    handshake_sync_rx_sync #(.WIDTH(1)) u_req_sync (
        .clk  (clk),
        .rstb (rstb),
        .ena  (ena),
        .d    (req_async),
        .q    (req_s)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state      <= IDLE;
            ack        <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            xfer_count <= '0;
`ifdef HS_TIMEOUT_EN
            timer       <= '0;
            err_timeout <= 1'b0;
`endif
        end else if (ena) begin
            case (state)
                IDLE: begin
                    // data_async is stable by the time req has crossed both stages
                    if (req_s) begin
                        data_out   <= data_async;
                        data_valid <= 1'b1;
                        state      <= OFFER;
                    end
                end
                OFFER: begin
                    if (data_ready) begin
                        data_valid <= 1'b0;
                        ack        <= 1'b1;
                        xfer_count <= xfer_count + 1'b1;
                        state      <= WAIT_REQ_LOW;
`ifdef HS_TIMEOUT_EN
                        timer      <= '0;
`endif
                    end
                end
                WAIT_REQ_LOW: begin
                    if (!req_s) begin
                        ack   <= 1'b0;
                        state <= IDLE;
`ifdef HS_TIMEOUT_EN
                    end else if (timer + 16'd1 == TIMEOUT_LIM) begin
                        ack         <= 1'b0;
                        err_timeout <= 1'b1;
                        state       <= DRAIN;
                    end else begin
                        timer <= timer + 16'd1;
`endif
                    end
                end
`ifdef HS_TIMEOUT_EN
                DRAIN: begin
                    // wait for the source to let go before accepting a new request
                    if (!req_s) state <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

`ifndef HS_TIMEOUT_EN
    assign err_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_handshake_sync_rx.sv
// Directed + randomized bench for handshake_sync_rx; transaction-level model of
// expected data, latency and transfer count.

module tb_handshake_sync_rx;
    logic       clk = 1'b0;
    logic       rstb;
    logic       ena;
    logic       req_async;
    logic [7:0] data_async;
    logic       ack;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic [7:0] xfer_count;
    logic       err_timeout;

    int vectors = 0;
    int miscompares = 0;
    int exp_cnt = 0;
    logic exp_err = 1'b0;

    handshake_sync_rx #(.WIDTH(8), .CNT_WIDTH(8), .TIMEOUT_CYCLES(4)) dut (
        .clk         (clk),
        .rstb        (rstb),
        .ena         (ena),
        .req_async   (req_async),
        .data_async  (data_async),
        .ack         (ack),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .xfer_count  (xfer_count),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transfer; hold = cycles of backpressure, early = req drops right after capture
    task automatic xfer(input logic [7:0] d, input int hold, input bit early);
        int h;
        h = (early && hold < 1) ? 1 : hold;
        data_async = d;
        req_async  = 1'b1;
        data_ready = 1'($urandom_range(0, 1));
        tick(); chk("cap_wait1", data_valid, 0);
        tick(); chk("cap_wait2", data_valid, 0);
        tick(); chk("valid_rise", data_valid, 1);
        chk("data_out", data_out, d);
        chk("ack_low_offer", ack, 0);
        if (early) req_async = 1'b0;
        for (int i = 0; i < h; i++) begin
            data_ready = 1'b0;
            tick();
            chk("bp_valid", data_valid, 1);
            chk("bp_data", data_out, d);
            chk("bp_ack", ack, 0);
        end
        data_ready = 1'b1;
        tick();
        exp_cnt = (exp_cnt + 1) % 256;
        chk("ack_rise", ack, 1);
        chk("valid_fall", data_valid, 0);
        chk("count", xfer_count, exp_cnt);
        data_ready = 1'($urandom_range(0, 1));
        data_async = 8'($urandom);
        if (early) begin
            tick(); chk("early_ack_pulse", ack, 0);
        end else begin
            req_async = 1'b0;
            tick(); chk("ack_hold1", ack, 1);
            tick(); chk("ack_hold2", ack, 1);
            tick(); chk("ack_fall", ack, 0);
        end
        chk("count_stable", xfer_count, exp_cnt);
        chk("err", err_timeout, exp_err);
    endtask

    initial begin
        rstb = 1'b0; ena = 1'b1; req_async = 1'b0; data_async = '0; data_ready = 1'b0;
        #2;
        chk("rst_ack", ack, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_data", data_out, 0);
        chk("rst_count", xfer_count, 0);
        chk("rst_err", err_timeout, 0);
        @(negedge clk); @(negedge clk);
        rstb = 1'b1;
        tick();

        // basic and backpressure
        xfer(8'hA5, 0, 1'b0);
        chk("basic_count", xfer_count, 1);
        xfer(8'h3C, 10, 1'b0);

        // ena gating while offering
        data_async = 8'h5A; req_async = 1'b1; data_ready = 1'b0;
        tick(); tick(); tick();
        chk("ena_valid", data_valid, 1);
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            data_ready = ~data_ready;
            tick();
            chk("ena_hold_valid", data_valid, 1);
            chk("ena_hold_ack", ack, 0);
            chk("ena_hold_data", data_out, 8'h5A);
            chk("ena_hold_cnt", xfer_count, exp_cnt);
        end
        ena = 1'b1; data_ready = 1'b1;
        tick();
        exp_cnt = (exp_cnt + 1) % 256;
        chk("ena_ack", ack, 1);
        chk("ena_cnt", xfer_count, exp_cnt);
        req_async = 1'b0;
        tick(); tick(); tick();
        chk("ena_ack_fall", ack, 0);
        chk("ena_cnt_once", xfer_count, exp_cnt);

        // early req drop
        xfer(8'($urandom), 2, 1'b1);

        // reset then 256 randomized transfers; counter must wrap to zero
        @(negedge clk); rstb = 1'b0; #1;
        exp_cnt = 0;
        chk("rst2_count", xfer_count, 0);
        @(negedge clk); rstb = 1'b1;
        tick();
        for (int i = 0; i < 256; i++)
            xfer(8'(i), int'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0));
        chk("wrap", xfer_count, 0);

        // asynchronous reset while ack is high
        data_async = 8'hC3; req_async = 1'b1; data_ready = 1'b1;
        tick(); tick(); tick(); tick();
        chk("pre_rst_ack", ack, 1);
        #2 rstb = 1'b0;
        #1;
        chk("async_rst_ack", ack, 0);
        chk("async_rst_valid", data_valid, 0);
        chk("async_rst_cnt", xfer_count, 0);
        #1 rstb = 1'b1;
        exp_cnt = 0;
        data_ready = 1'b0;
        tick(); tick();
        chk("recap_wait", data_valid, 0);
        tick();
        chk("recap_valid", data_valid, 1);
        chk("recap_data", data_out, 8'hC3);
        data_ready = 1'b1;
        tick();
        exp_cnt = 1;
        chk("recap_cnt", xfer_count, exp_cnt);

        // req held high after ack
`ifdef HS_TIMEOUT_EN
        tick(); tick(); tick();
        chk("to_ack_before", ack, 1);
        chk("to_err_before", err_timeout, 0);
        tick();
        exp_err = 1'b1;
        chk("to_ack_fall", ack, 0);
        chk("to_err", err_timeout, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("drain_no_cap", data_valid, 0);
        end
        req_async = 1'b0;
        tick(); tick(); tick();
        xfer(8'h96, 0, 1'b0);
        chk("err_sticky", err_timeout, 1);
`else
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("wait_ack_held", ack, 1);
        end
        req_async = 1'b0;
        tick(); tick(); tick();
        chk("wait_ack_fall", ack, 0);
        chk("no_timeout", err_timeout, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/handshake_sync_rx.md
Name: handshake_sync_rx

Overview:
- Receiver-side controller for a 4-phase req/ack bundled-data transfer from an asynchronous source, e.g. the external operand/opcode pins feeding the 74181 ALU core.
- Synchronizes `req_async` through an internal 2-stage synchronizer instance (WIDTH=1) and captures `data_async` only after req is seen stable.
- Presents the captured data to the ALU-side consumer with a valid/ready handshake, then sequences `ack` back to the source.
- Counts completed transfers.

Parameters:
- WIDTH, 8, width of the bundled data bus.
- CNT_WIDTH, 8, width of the transfer counter.
- TIMEOUT_CYCLES, 255, cycles of req-high in WAIT_REQ_LOW before timeout. Used only with HS_TIMEOUT_EN; must be ≥1 and fit in 16 bits.

Ports:
- clk  input  1  system clock.
- rstb  input  1  reset, active-low, asynchronous.
- ena  input  1  clock enable. When low, every register (including the synchronizer stages) holds its value.
- req_async  input  1  request from the asynchronous source.
- data_async  input  WIDTH  bundled data. The source guarantees it is stable from req rise until ack rise.
- ack  output  1  acknowledge to the source.
- data_out  output  WIDTH  captured data.
- data_valid  output  1  data_out valid for the consumer.
- data_ready  input  1  consumer accepts data_out.
- xfer_count  output  CNT_WIDTH  number of completed transfers; wraps modulo 2^CNT_WIDTH.
- err_timeout  output  1  sticky timeout flag. Tied to 0 without HS_TIMEOUT_EN.

Behaviour:
- Clock and reset: one clock `clk`. `rstb` is asynchronous and active-low.
- Reset values:
  - state = IDLE
  - ack = 0, data_valid = 0, data_out = 0
  - xfer_count = 0, err_timeout = 0
  - synchronizer stages = 0
- req_s: req_async after 2 enabled clk edges. The FSM uses only req_s.
- All outputs are registered. All transitions below occur on enabled edges only (ena=1).
- IDLE:
  - If req_s=1: data_out <= data_async, data_valid <= 1, go to OFFER.
  - Latency: data_valid rises 3 enabled edges after req_async rises, counting edges with req_async already high.
- OFFER:
  - data_valid=1 and data_out is held stable.
  - On an edge with data_ready=1: data_valid <= 0, ack <= 1, xfer_count <= xfer_count+1, go to WAIT_REQ_LOW.
  - data_ready=1 in other states is ignored.
- WAIT_REQ_LOW:
  - ack held at 1.
  - If req_s=0: ack <= 0, go to IDLE.
  - A new transfer cannot start before returning to IDLE, so each req pulse is captured exactly once.
- req_async dropping early: if req_async falls before ack (protocol violation), the transfer still completes normally. On reaching WAIT_REQ_LOW with req_s=0, ack pulses for exactly 1 cycle.
- Counter: xfer_count wraps from 2^CNT_WIDTH-1 to 0 with no flag.
- ena low mid-operation: state, outputs and counter freeze. There is no loss or duplication of transfers.
- rstb asserted mid-operation: immediately returns to reset values. ack drops asynchronously and any data held in OFFER is discarded.

Optional Feature:
- Macro: HS_TIMEOUT_EN.
- With HS_TIMEOUT_EN, a 16-bit timer runs in WAIT_REQ_LOW:
  - Cleared on entry to WAIT_REQ_LOW.
  - Increments each enabled cycle while req_s=1.
  - When it reaches TIMEOUT_CYCLES: ack <= 0, err_timeout <= 1 (sticky until rstb), go to state DRAIN.
- DRAIN: ack=0. Go to IDLE when req_s=0.
- Without HS_TIMEOUT_EN: no timer and no DRAIN state. err_timeout is constant 0. WAIT_REQ_LOW waits indefinitely.

Test Plan:
1. Basic transfer:
   - Stimulus: rstb pulse, ena=1, data_ready=1, data_async=0xA5, raise req_async.
   - Response: data_valid high with data_out=0xA5 on the 3rd edge after the req rise. ack=1 the next edge. Drop req: ack=0 three edges later. xfer_count=1.
2. Backpressure:
   - Stimulus: data_ready=0 for 10 cycles after data_valid rises.
   - Response: data_valid and data_out=0x3C held for all 10 cycles, ack stays 0. ack rises 1 edge after data_ready=1.
3. ena gating:
   - Stimulus: deassert ena for 5 cycles while in OFFER, toggling data_ready.
   - Response: no state or output change. Transfer completes normally once ena=1. xfer_count increments exactly once.
4. Counter wrap (CNT_WIDTH=8):
   - Stimulus: 256 back-to-back transfers with data = index.
   - Response: each data_out matches its index. xfer_count returns to 0 after transfer 256.
5. Reset mid-transfer:
   - Stimulus: assert rstb low while ack=1, asynchronously to clk.
   - Response: ack, data_valid and xfer_count go to 0 without a clk edge. After release with req_async still high, a fresh capture occurs.
6. Timeout (HS_TIMEOUT_EN, TIMEOUT_CYCLES=4):
   - Stimulus: hold req_async high after ack.
   - Response: ack falls and err_timeout=1 after 4 cycles in WAIT_REQ_LOW. No new capture until req is low then high. err_timeout stays 1.
